// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle MIPS-lite controller.
//   - FSM state codes (FETCH..WB; codes 5-7 are unused)
//   - opcode/funct constants for the supported subset
//   - datapath select encodings (pc_src, reg_dst, wd_sel, alu_op)
//   - dec_t: one-hot instruction class flags produced by mc_instr_decode
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;

  // PC source select
  localparam logic [1:0] PC_SEQ = 2'd0;  // PC+4
  localparam logic [1:0] PC_BR  = 2'd1;  // PC + (sext(imm) << 2)
  localparam logic [1:0] PC_JMP = 2'd2;  // jump target
  localparam logic [1:0] PC_RS  = 2'd3;  // register rs

  // Register destination select
  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;   // $31

  // Register write-data select
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  // ALU operation
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] ALU_LUI = 2'd3;

  // One-hot instruction class; bad marks an unsupported encoding.
  typedef struct packed {
    logic add;
    logic sub;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic bad;
  } dec_t;

endpackage

// File: rtl/mc_instr_decode.sv
// mc_instr_decode: purely combinational opcode/funct classifier.
//   opcode in 6  IR[31:26]
//   funct  in 6  IR[5:0]
//   dec    out   one-hot class flags; exactly one bit of dec_t is set
module mc_instr_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_R: begin
        case (funct)
          FN_ADD:  dec.add = 1'b1;
          FN_SUB:  dec.sub = 1'b1;
          FN_JR:   dec.jr  = 1'b1;
          default: dec.bad = 1'b1;
        endcase
      end
      OP_ORI:  dec.ori = 1'b1;
      OP_LUI:  dec.lui = 1'b1;
      OP_LW:   dec.lw  = 1'b1;
      OP_SW:   dec.sw  = 1'b1;
      OP_BEQ:  dec.beq = 1'b1;
      OP_J:    dec.j   = 1'b1;
      OP_JAL:  dec.jal = 1'b1;
      default: dec.bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle MIPS-lite control FSM.
// Sequences PC/IR/regfile/ALU/unified memory through FETCH, DECODE, EXEC,
// MEM and WB, with a req/ready handshake on the memory port.
// Ports:
//   clk, reset (sync, active-low)
//   opcode, funct      instruction fields from IR
//   alu_zero           ALU zero flag (used by beq in EXEC)
//   mem_ready          memory completes the current access
//   mem_req/sel/we     memory request, address select, write strobe
//   ir_write, pc_write, pc_src       IR/PC update controls
//   reg_write, reg_dst, wd_sel       register-file write controls
//   alu_op, alu_src_b, ext_op        ALU controls
//   illegal            pulse on unsupported encoding in DECODE
//   retire, retire_cnt pulse in final cycle of an instruction + counter
//   state              current FSM state for debug
// Only the state register and retire_cnt are storage; every other output
// is combinational from state, decode flags and alu_zero/mem_ready.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_sel,
  output logic                mem_we,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          wd_sel,
  output logic [1:0]          alu_op,
  output logic                alu_src_b,
  output logic                ext_op,
  output logic                illegal,
  output logic                retire,
  output logic [RETIRE_W-1:0] retire_cnt,
  output logic [2:0]          state
);

  state_t state_q;
  state_t state_d;
  dec_t   dec;

  mc_instr_decode u_dec (
    .opcode (opcode),
    .funct  (funct),
    .dec    (dec)
  );

  // Outputs and next state. Everything is forced to zero while reset is low
  // so the datapath sees no strobes before the first reset edge.
  always_comb begin
    state_d   = S_FETCH;
    mem_req   = 1'b0;
    mem_sel   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SEQ;
    reg_write = 1'b0;
    reg_dst   = RD_RT;
    wd_sel    = WD_ALU;
    alu_op    = ALU_ADD;
    alu_src_b = 1'b0;
    ext_op    = 1'b0;
    illegal   = 1'b0;
    retire    = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else begin
            state_d  = S_FETCH;
          end
        end

        S_DECODE: begin
          // PC already holds instr+4, which is what jal links into $31;
          // the regfile samples it before the PC edge overwrites it.
          if (dec.j || dec.jal) begin
            pc_write = 1'b1;
            pc_src   = PC_JMP;
            retire   = 1'b1;
            if (dec.jal) begin
              reg_write = 1'b1;
              reg_dst   = RD_RA;
              wd_sel    = WD_PC;
            end
            state_d  = S_FETCH;
          end else if (dec.jr) begin
            pc_write = 1'b1;
            pc_src   = PC_RS;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else if (dec.bad) begin
            // Unsupported encoding behaves as a nop that does not retire.
            illegal  = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d  = S_EXEC;
          end
        end

        S_EXEC: begin
          if (dec.sub || dec.beq) begin
            alu_op = ALU_SUB;
          end else if (dec.ori) begin
            alu_op    = ALU_OR;
            alu_src_b = 1'b1;
          end else if (dec.lui) begin
            alu_op    = ALU_LUI;
            alu_src_b = 1'b1;
          end else if (dec.lw || dec.sw) begin
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            ext_op    = 1'b1;
          end
          if (dec.beq) begin
            pc_write = alu_zero;
            pc_src   = PC_BR;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else if (dec.lw || dec.sw) begin
            state_d  = S_MEM;
          end else begin
            state_d  = S_WB;
          end
        end

        S_MEM: begin
          // Request stays up with stable sel/we until the memory answers.
          mem_req = 1'b1;
          mem_sel = 1'b1;
          mem_we  = dec.sw;
          if (!mem_ready)  state_d = S_MEM;
          else if (dec.sw) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end

        S_WB: begin
          reg_write = 1'b1;
          reg_dst   = (dec.add || dec.sub) ? RD_RD : RD_RT;
          wd_sel    = dec.lw ? WD_MEM : WD_ALU;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end

        // Unused codes recover to FETCH with every strobe low.
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign state = reset ? state_q : 3'd0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      retire_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (retire)
        retire_cnt <= retire_cnt + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
